display_scheduler: RTL and testbench
====================================

Name: display_scheduler

Overview:
- Shares the two-digit 7-segment display driver between N requesters.
- Each requester posts a 7-bit binary value with a request. The block grants requesters round-robin and converts the granted value to two BCD digits with a sequential shift-add-3 (double-dabble) engine.
- The BCD byte is presented to the display driver's bcd_i input and held for a programmable dwell time.
- Sits between producer blocks (e.g. gray decoder, counters) and the 7-segment driver.

Parameters:
- N_REQ, 2, number of requesters (2..8)
- DWELL_CYCLES, 27000000, clock cycles each granted value is held on display (>=1)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-low reset
- req_i  in  N_REQ  per-requester request, level, held until ack
- data_i  in  7*N_REQ  packed binary values; requester k at bits [7k+6:7k]
- ack_o  out  N_REQ  one-cycle grant/accept pulse; data latched on the same edge
- bcd_o  out  8  [7:4] tens digit, [3:0] units digit, to display driver bcd_i
- src_o  out  $clog2(N_REQ) (min 1)  index of requester currently shown
- busy_o  out  1  high in CONVERT and SHOW

Behaviour:
- Reset (async, rst_i=0) puts the block in this state:
  - state=IDLE, bcd_o=8'h00, src_o=0, ack_o=0, busy_o=0
  - round-robin pointer=0, dwell counter=DWELL_CYCLES-1
  - Reset mid-conversion or mid-dwell aborts immediately. No ack is repeated after reset.
- FSM has three states:
  - IDLE. If any req_i is high at a rising edge, select the first set bit searching from pointer upward with wrap. On that edge:
    - latch its data_i
    - assert ack_o[k] for exactly one cycle
    - set src_o=k and pointer=(k+1) mod N_REQ
    - clear shift register
    - go to CONVERT
  - CONVERT:
    - Runs 7 iterations, one per clock: for each BCD nibble >=5 add 3, then shift left one bit, taking the next binary MSB.
    - On the 7th iteration edge, bcd_o is updated atomically and the state goes to SHOW.
    - bcd_o never shows partial results.
  - SHOW:
    - Dwell counter counts DWELL_CYCLES-1 down to 0.
    - At 0, reload the counter and go to IDLE.
    - req_i is ignored while busy; no preemption.
- Latency:
  - req sampled at edge E → ack_o high in cycle E..E+1.
  - New bcd_o visible after edge E+7.
  - Display holds for DWELL_CYCLES cycles.
  - Next grant is possible at the first edge after returning to IDLE, so back-to-back period = 1 + 7 + DWELL_CYCLES cycles.
- Overflow: a latched value >99 produces bcd_o=8'hFF (both digits blank on the driver) after the same 7-cycle latency.
- Withdrawn request: a requester dropping req_i before its ack is never granted, and nothing is latched for it.
- Idle display: with no requests, bcd_o and src_o hold the last shown value indefinitely.
- Simultaneous requests: the round-robin order guarantees each active requester a grant within N_REQ grants.
- Width rules:
  - 7-bit input and 8-bit BCD accumulator.
  - Add-3 is done per nibble, with no carry between nibbles.
  - Overflow compare is made on the latched binary value.

Decomposition:
- Shared package display_pkg holds:
  - state encoding (IDLE, CONVERT, SHOW)
  - BIN_W=7, BCD_W=8, CONV_ITER=7, BCD_BLANK=8'hFF
- Natural sub-module bin2bcd_seq:
  - Inputs: start, 7-bit bin. Outputs: done pulse, 8-bit bcd, overflow.
  - Owns the shift register and iteration counter.
- The scheduler owns the arbiter, FSM, dwell counter and output registers.

Test Plan (N_REQ=2, DWELL_CYCLES=4 unless stated):
1. Reset: hold rst_i=0 for 3 cycles with req_i=2'b11 → bcd_o=8'h00, ack_o=0, busy_o=0. Assert rst_i=0 asynchronously mid-CONVERT → outputs clear without waiting for a clock edge.
2. Single conversion: req_i=2'b01, data_i[6:0]=7'd57 → ack_o=2'b01 for one cycle after edge E; bcd_o=8'h57 after edge E+7; busy_o high for 11 cycles; src_o=0.
3. Round-robin: both requesting continuously, data 7'd12 and 7'd99 → bcd_o sequence 8'h12, 8'h99, 8'h12 …; acks alternate 01, 10, 01; grants spaced 12 cycles apart.
4. Boundaries: values 0, 9, 10, 99 → 8'h00, 8'h09, 8'h10, 8'h99. Values 100 and 127 → 8'hFF.
5. Withdrawal and hold: req_i[1] pulses high while busy and drops before IDLE → no ack_o[1]. Afterwards, with req_i=0 for 50 cycles, bcd_o remains at the last value.
6. Dwell: DWELL_CYCLES=1 → SHOW lasts exactly 1 cycle. A continuous single requester is re-acked every 9 cycles.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the display scheduler slice.
// Holds the FSM encoding and the BCD add-3 helper.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    SHOW
  } state_e;

  localparam int BIN_W     = 7;
  localparam int BCD_W     = 8;
  localparam int CONV_ITER = 7;

  localparam logic [BCD_W-1:0] BCD_BLANK = 8'hFF;
  localparam logic [BIN_W-1:0] BIN_MAX   = 7'd99;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 7-bit binary to two BCD digits.
// done_o marks the cycle whose edge completes the last shift.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o,
  output logic             ovf_o
);

  localparam int SH_W = BCD_W + BIN_W;
  localparam int IT_W = $clog2(CONV_ITER);

  logic [SH_W-1:0] r_sh;
  logic [SH_W-1:0] w_sh_nxt;
  logic [IT_W-1:0] r_it;
  logic            r_run;
  logic            r_ovf;

  // Tens carry-out beyond 8 bits only occurs for values >99, which blank anyway.
  assign w_sh_nxt = {3'(add3(r_sh[SH_W-1 -: 4])),
                     add3(r_sh[SH_W-5 -: 4]),
                     r_sh[BIN_W-1:0], 1'b0};

  assign done_o = r_run && (r_it == IT_W'(CONV_ITER - 1));
  assign bcd_o  = w_sh_nxt[SH_W-1 -: BCD_W];
  assign ovf_o  = r_ovf;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_sh  <= '0;
      r_it  <= '0;
      r_run <= 1'b0;
      r_ovf <= 1'b0;
    end else if (start_i) begin
      r_sh  <= {{BCD_W{1'b0}}, bin_i};
      r_it  <= '0;
      r_run <= 1'b1;
      r_ovf <= (bin_i > BIN_MAX);
    end else if (r_run) begin
      r_sh <= w_sh_nxt;
      r_it <= r_it + IT_W'(1);
      if (done_o) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Round-robin sharing of the two-digit BCD display between requesters.
// Grants, converts the latched value, then holds it for a dwell time.
module display_scheduler
  import display_pkg::*;
#(
  parameter  int N_REQ        = 2,
  parameter  int DWELL_CYCLES = 27000000,
  localparam int SRC_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [BIN_W*N_REQ-1:0] data_i,
  output logic [N_REQ-1:0]       ack_o,
  output logic [BCD_W-1:0]       bcd_o,
  output logic [SRC_W-1:0]       src_o,
  output logic                   busy_o
);

  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL_CYCLES - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [SRC_W-1:0] r_ptr;
  logic [SRC_W-1:0] r_src;
  logic [SRC_W-1:0] w_k;
  logic [SRC_W-1:0] w_ptr_nxt;
  logic [N_REQ-1:0] r_ack;
  logic [N_REQ-1:0] w_onehot;
  logic [BIN_W-1:0] w_sel;
  logic [BCD_W-1:0] r_bcd;
  logic [BCD_W-1:0] w_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic             w_found;
  logic             w_start;
  logic             w_done;
  logic             w_ovf;
  int               w_idx;

  // First pending request at or after the pointer, wrapping.
  always_comb begin
    w_found   = 1'b0;
    w_k       = '0;
    w_ptr_nxt = '0;
    w_onehot  = '0;
    w_sel     = '0;
    w_idx     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (!w_found && req_i[w_idx]) begin
        w_found   = 1'b1;
        w_k       = SRC_W'(w_idx);
        w_onehot  = N_REQ'(1) << w_idx;
        w_sel     = data_i[BIN_W*w_idx +: BIN_W];
        w_ptr_nxt = (w_idx == N_REQ - 1) ? '0 : SRC_W'(w_idx + 1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_start     = 1'b1;
          w_state_nxt = CONVERT;
        end
      end
      CONVERT: if (w_done) w_state_nxt = SHOW;
      SHOW:    if (r_cnt == '0) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ptr <= '0;
      r_src <= '0;
      r_ack <= '0;
      r_bcd <= '0;
      r_cnt <= CNT_LOAD;
    end else begin
      r_ack <= w_start ? w_onehot : '0;
      if (w_start) begin
        r_src <= w_k;
        r_ptr <= w_ptr_nxt;
      end
      if (r_state == CONVERT && w_done)
        r_bcd <= w_ovf ? BCD_BLANK : w_bcd;
      if (r_state == SHOW)
        r_cnt <= (r_cnt == '0) ? CNT_LOAD : r_cnt - CNT_W'(1);
    end
  end

  bin2bcd_seq u_conv (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (w_start),
    .bin_i   (w_sel),
    .done_o  (w_done),
    .bcd_o   (w_bcd),
    .ovf_o   (w_ovf)
  );

  assign ack_o  = r_ack;
  assign bcd_o  = r_bcd;
  assign src_o  = r_src;
  assign busy_o = (r_state != IDLE);

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler: tables, corner sequences,
// and random traffic against a decimal/round-robin reference model.
module tb_display_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  req, req_b;
  logic [13:0] data, data_b;
  logic [1:0]  ack, ack_b;
  logic [7:0]  bcd, bcd_b;
  logic        src, src_b;
  logic        busy, busy_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int m_ptr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  display_scheduler #(.N_REQ(2), .DWELL_CYCLES(4)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .req_i(req), .data_i(data),
    .ack_o(ack), .bcd_o(bcd), .src_o(src), .busy_o(busy)
  );

  display_scheduler #(.N_REQ(2), .DWELL_CYCLES(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req_b), .data_i(data_b),
    .ack_o(ack_b), .bcd_o(bcd_b), .src_o(src_b), .busy_o(busy_b)
  );

  typedef struct {
    int         k;
    logic [6:0] val;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out got none want event", name);
  endtask

  function automatic logic [7:0] ref_bcd(input int v);
    if (v > 99) return 8'hFF;
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int ref_pick(input logic [1:0] r);
    for (int i = 0; i < 2; i++)
      if (r[(m_ptr + i) % 2]) return (m_ptr + i) % 2;
    return -1;
  endfunction

  task automatic wait_ack(input string name, output int k, output int t);
    k = -1;
    t = 0;
    for (int i = 0; i < 40 && k < 0; i++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        k = ack[1] ? 1 : 0;
        t = cyc;
      end
    end
    if (k < 0) timeout({name, " ack"});
  endtask

  task automatic serve(input string name, input int exp_k,
                       input logic [7:0] exp_v, input bit drop,
                       input bit scramble, output int t);
    int k;
    int nb;
    logic [7:0] old;
    bit clean;
    old = bcd;
    wait_ack(name, k, t);
    if (k < 0) return;
    chk({name, " ack"}, 32'(ack), 32'(2'b01 << exp_k));
    chk({name, " src"}, 32'(src), 32'(exp_k));
    m_ptr = (exp_k + 1) % 2;
    if (drop) req[exp_k] = 1'b0;
    if (scramble) data = 14'($urandom);
    nb = int'(busy);
    clean = 1'b1;
    for (int i = 1; i < 7; i++) begin
      @(negedge clk);
      if (bcd !== old || ack !== 2'b00) clean = 1'b0;
      nb += int'(busy);
    end
    chk({name, " hold"}, 32'(clean), 32'd1);
    @(negedge clk);
    nb += int'(busy);
    chk({name, " bcd"}, 32'(bcd), 32'(exp_v));
    for (int i = 0; i < 30 && busy; i++) begin
      @(negedge clk);
      nb += int'(busy);
    end
    chk({name, " busy"}, 32'(nb), 32'd11);
  endtask

  initial begin
    int k, t, prev, t0, t1;
    bit quiet;
    logic [1:0] r;
    logic [7:0] ev;

    tbl[0] = '{0, 7'd0,   8'h00};
    tbl[1] = '{1, 7'd9,   8'h09};
    tbl[2] = '{0, 7'd10,  8'h10};
    tbl[3] = '{1, 7'd99,  8'h99};
    tbl[4] = '{0, 7'd100, 8'hFF};
    tbl[5] = '{1, 7'd127, 8'hFF};
    tbl[6] = '{0, 7'd1,   8'h01};
    tbl[7] = '{1, 7'd50,  8'h50};

    rst_n  = 1'b0;
    req    = 2'b11;
    data   = {7'd99, 7'd12};
    req_b  = 2'b00;
    data_b = '0;
    repeat (3) @(negedge clk);
    chk("rst bcd", 32'(bcd), 32'h00);
    chk("rst ack", 32'(ack), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst src", 32'(src), 32'h0);
    rst_n = 1'b1;
    req   = 2'b00;
    @(negedge clk);

    req = 2'b01;
    data[6:0] = 7'd57;
    serve("single", 0, 8'h57, 1'b1, 1'b0, t);

    req = 2'b10;
    data[13:7] = 7'd12;
    wait_ack("abort", k, t);
    chk("abort ack", 32'(ack), 32'h2);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'h0);
    chk("abort bcd", 32'(bcd), 32'h00);
    chk("abort src", 32'(src), 32'h0);
    req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    quiet = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (ack !== 2'b00) quiet = 1'b0;
    end
    chk("no re-ack", 32'(quiet), 32'd1);

    data = {7'd99, 7'd12};
    req  = 2'b11;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      k = ref_pick(req);
      serve($sformatf("rr%0d", i), k, (k == 1) ? 8'h99 : 8'h12,
            1'b0, 1'b0, t);
      if (i > 0) chk($sformatf("rr%0d gap", i), 32'(t - prev), 32'd12);
      prev = t;
    end
    req = 2'b00;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      req = 2'b01 << tbl[i].k;
      data[7*tbl[i].k +: 7] = tbl[i].val;
      serve($sformatf("tbl%0d", i), ref_pick(req), tbl[i].exp,
            1'b1, 1'b1, t);
    end

    req = 2'b01;
    data[6:0] = 7'd33;
    wait_ack("wd", k, t);
    chk("wd ack", 32'(ack), 32'h1);
    m_ptr = 1;
    req = 2'b00;
    quiet = 1'b1;
    repeat (2) @(negedge clk);
    req[1] = 1'b1;
    data[13:7] = 7'd44;
    repeat (3) begin
      @(negedge clk);
      if (ack !== 2'b00) quiet = 1'b0;
    end
    req[1] = 1'b0;
    for (int i = 0; i < 30 && busy; i++) begin
      @(negedge clk);
      if (ack !== 2'b00) quiet = 1'b0;
    end
    repeat (50) begin
      @(negedge clk);
      if (ack !== 2'b00) quiet = 1'b0;
    end
    chk("wd no ack", 32'(quiet), 32'd1);
    chk("wd hold bcd", 32'(bcd), 32'h33);
    chk("wd hold src", 32'(src), 32'h0);

    for (int i = 0; i < 30; i++) begin
      r    = 2'($urandom_range(1, 3));
      req  = r;
      data = 14'($urandom);
      k    = ref_pick(req);
      ev   = ref_bcd(int'(data[7*k +: 7]));
      serve($sformatf("rnd%0d", i), k, ev, 1'b0, 1'b1, t);
    end
    req = 2'b00;

    req_b = 2'b01;
    data_b[6:0] = 7'd20;
    t0 = -1;
    for (int i = 0; i < 20 && t0 < 0; i++) begin
      @(negedge clk);
      if (ack_b == 2'b01) t0 = cyc;
    end
    if (t0 < 0) timeout("d1 ack0");
    for (int j = 0; j < 2; j++) begin
      k = int'(busy_b);
      for (int i = 0; i < 20 && busy_b; i++) begin
        @(negedge clk);
        k += int'(busy_b);
      end
      chk($sformatf("d1 busy%0d", j), 32'(k), 32'd8);
      chk($sformatf("d1 bcd%0d", j), 32'(bcd_b), 32'h20);
      t1 = -1;
      for (int i = 0; i < 20 && t1 < 0; i++) begin
        @(negedge clk);
        if (ack_b == 2'b01) t1 = cyc;
      end
      if (t1 < 0) timeout($sformatf("d1 ack%0d", j + 1));
      else chk($sformatf("d1 gap%0d", j), 32'(t1 - t0), 32'd9);
      t0 = t1;
    end
    req_b = 2'b00;
    repeat (12) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
